// File: rtl/cla_seq_arbiter.sv
// Two-requester adder service built around a single 4-bit carry-lookahead
// slice. An accepted operation is summed one nibble per RUN cycle, with the
// carry kept in a register between nibbles. Ties between the two requesters
// are broken round-robin.

// 4-bit carry-lookahead adder slice: all carries computed from generate/propagate.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = c0;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);
    assign s    = p ^ c[3:0];
    assign c4   = c[4];
endmodule

module cla_seq_arbiter #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [4*NIB-1:0] req0_a,
    input  logic [4*NIB-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4*NIB-1:0] req1_a,
    input  logic [4*NIB-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4*NIB-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);
    localparam int W  = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          id_q, id_d;
    logic          rr_q, rr_d;      // index of the requester served last
    logic [CW-1:0] cnt_q, cnt_d;

    logic          grant1;
    logic          accept;
    logic [3:0]    a_nib [NIB];
    logic [3:0]    b_nib [NIB];
    logic [3:0]    cla_s;
    logic          cla_c4;

    // Split the captured operands into nibbles for the time-shared slice.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_q[gi*4 +: 4];
            assign b_nib[gi] = b_q[gi*4 +: 4];
        end
    endgenerate

    cla4 u_cla (
        .a  (a_nib[cnt_q]),
        .b  (b_nib[cnt_q]),
        .c0 (carry_q),
        .s  (cla_s),
        .c4 (cla_c4)
    );

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign grant1     = req1_valid & (~req0_valid | ~rr_q);
    assign accept     = (state_q == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = (state_q == IDLE) & req0_valid & ~grant1;
    assign req1_ready = (state_q == IDLE) & grant1;

    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_sum    = sum_q;
    assign rsp_cout   = carry_q;
    assign rsp_id     = id_q;

    // State register with asynchronous abort; pointer resets so requester 0 wins first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            rr_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: capture on accept, one nibble per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    a_d     = grant1 ? req1_a   : req0_a;
                    b_d     = grant1 ? req1_b   : req0_b;
                    carry_d = grant1 ? req1_cin : req0_cin;
                    id_d    = grant1;
                    rr_d    = grant1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sum_d[cnt_q*4 +: 4] = cla_s;
                carry_d             = cla_c4;
                cnt_d               = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cla_seq_arbiter.sv
// Directed bench for cla_seq_arbiter: arithmetic, latency, arbitration order,
// response hold, reset abort and operand capture.
module tb_cla_seq_arbiter;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout, rsp_id, busy;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_arbiter #(.NIB(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Present one request, wait for accept, scramble operands, count edges to response, handshake.
    task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin,
                          output int lat, output logic [W-1:0] s, output logic co,
                          output logic rid, output bit to);
        bit acc = 1'b0;
        to = 1'b0; lat = 0; s = '0; co = 1'b0; rid = 1'b0;
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            acc = (id == 1'b0) ? req0_ready : req1_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (id == 1'b0) begin
            req0_a = ~a; req0_b = ~b; req0_cin = ~cin;
        end else begin
            req1_a = ~a; req1_b = ~b; req1_cin = ~cin;
        end
        if (!acc) begin
            to = 1'b1;
        end else begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                lat++;
                if (rsp_valid) break;
            end
            if (!rsp_valid) to = 1'b1;
            s = rsp_sum; co = rsp_cout; rid = rsp_id;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        $display("txn req%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d id=%0d lat=%0d", id, a, b, cin, s, co, rid, lat);
    endtask

    task automatic test_reset;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, busy, rsp_sum, rsp_cout, rsp_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b busy=%b sum=%h cout=%b id=%b expected all zero",
                     rsp_valid, busy, rsp_sum, rsp_cout, rsp_id);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_tie_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_basic;
        int lat; logic [W-1:0] s; logic co, rid; bit to;
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, lat, s, co, rid, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", to); end
        n_checks++;
        if (lat !== NIB) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, NIB); end
        n_checks++;
        if (s !== 16'h5555) begin n_fail++; $display("FAIL basic_sum: got %h expected 5555", s); end
        n_checks++;
        if (co !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b expected 0", co); end
        n_checks++;
        if (rid !== 1'b0) begin n_fail++; $display("FAIL basic_id: got %b expected 0", rid); end
    endtask

    task automatic test_carry;
        int lat; logic [W-1:0] s; logic co, rid; bit to;
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, lat, s, co, rid, to);
        n_checks++;
        if ({to, s, co, rid} !== {1'b0, 16'h0000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL carry_wrap: got to=%b sum=%h cout=%b id=%b expected to=0 sum=0000 cout=1 id=1", to, s, co, rid);
        end
        run_op(1'b1, 16'h7FFF, 16'h0000, 1'b1, lat, s, co, rid, to);
        n_checks++;
        if ({to, s, co, rid} !== {1'b0, 16'h8000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL carry_ripple: got to=%b sum=%h cout=%b id=%b expected to=0 sum=8000 cout=0 id=1", to, s, co, rid);
        end
        n_checks++;
        if (lat !== NIB) begin n_fail++; $display("FAIL carry_latency: got %0d expected %0d", lat, NIB); end
    endtask

    task automatic test_round_robin;
        logic         got_id [4];
        logic [W-1:0] got_sum [4];
        int n = 0;
        int both = 0;
        req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0;
        req1_a = 16'h0002; req1_b = 16'h0002; req1_cin = 1'b0;
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rr_first_tie: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_first_edge_accept: busy got %b expected 1", busy); end
        for (int c = 0; c < 80 && n < 4; c++) begin
            if (req0_ready && req1_ready) both++;
            if (rsp_valid && rsp_ready) begin
                got_id[n] = rsp_id; got_sum[n] = rsp_sum;
                $display("txn rr served id=%0d sum=%h", rsp_id, rsp_sum);
                n++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        n_checks++;
        if (n !== 4) begin n_fail++; $display("FAIL rr_count: got %0d expected 4", n); end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (got_id[i] !== i[0]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", i, got_id[i], i[0]);
            end
            n_checks++;
            if (got_sum[i] !== (i[0] ? 16'h0004 : 16'h0002)) begin
                n_fail++; $display("FAIL rr_sum[%0d]: got %h expected %h", i, got_sum[i], i[0] ? 16'h0004 : 16'h0002);
            end
        end
        n_checks++;
        if (both !== 0) begin n_fail++; $display("FAIL rr_both_ready: got %0d cycles expected 0", both); end
    endtask

    task automatic test_hold_done;
        bit acc = 1'b0;
        req1_a = 16'h00F0; req1_b = 16'h0F0F; req1_cin = 1'b0; req1_valid = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1; acc = req1_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        req1_valid = 1'b0;
        req0_a = 16'h0003; req0_b = 16'h0004; req0_cin = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            @(posedge clk); #1;
        end
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id} !== {1'b1, 16'h0FFF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_first_rsp: got v=%b sum=%h cout=%b id=%b expected v=1 sum=0fff cout=0 id=1",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({rsp_valid, busy, req0_ready, req1_ready, rsp_cout, rsp_id, rsp_sum} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0FFF}) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got v=%b busy=%b rdy=%b%b cout=%b id=%b sum=%h expected v=1 busy=1 rdy=00 cout=0 id=1 sum=0fff",
                         k, rsp_valid, busy, req0_ready, req1_ready, rsp_cout, rsp_id, rsp_sum);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, busy, req0_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL hold_idle_gap: got v/busy/rdy0=%b expected 001", {rsp_valid, busy, req0_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_next_accept: busy got %b expected 1", busy); end
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            @(posedge clk); #1;
        end
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id} !== {1'b1, 16'h0007, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_second_rsp: got v=%b sum=%h cout=%b id=%b expected v=1 sum=0007 cout=0 id=0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        $display("txn hold sequence done sum=%h id=%0d", rsp_sum, rsp_id);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_abort;
        bit acc = 1'b0;
        int lat; logic [W-1:0] s; logic co, rid; bit to;
        req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1; acc = req0_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        req0_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_running: busy got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, busy, rsp_sum, rsp_cout, rsp_id} !== '0) begin
            n_fail++;
            $display("FAIL abort_immediate: got v=%b busy=%b sum=%h cout=%b id=%b expected all zero",
                     rsp_valid, busy, rsp_sum, rsp_cout, rsp_id);
        end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL abort_no_response: got v/busy=%b expected 00", {rsp_valid, busy});
        end
        run_op(1'b0, 16'hA5A5, 16'h5A5A, 1'b1, lat, s, co, rid, to);
        n_checks++;
        if ({to, s, co} !== {1'b0, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_followup: got to=%b sum=%h cout=%b expected to=0 sum=0000 cout=1", to, s, co);
        end
    endtask

    task automatic test_operand_change;
        int lat; logic [W-1:0] s; logic co, rid; bit to;
        run_op(1'b1, 16'h0102, 16'h0304, 1'b0, lat, s, co, rid, to);
        n_checks++;
        if ({to, s, co, rid} !== {1'b0, 16'h0406, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL operand_capture: got to=%b sum=%h cout=%b id=%b expected to=0 sum=0406 cout=0 id=1", to, s, co, rid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_hold_done();
        test_reset_abort();
        test_operand_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cla_seq_arbiter.md
CLA_SEQ_ARBITER -- requirements
Module: cla_seq_arbiter

Interface
REQ-001 The block SHALL have parameter NIB, default 4, giving the number of 4-bit CLA slices per operand; operand width W = 4*NIB.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 bit: requester N presents an operation.
REQ-005 The block SHALL have ports req0_a / req1_a and req0_b / req1_b, input, W bits: operands.
REQ-006 The block SHALL have ports req0_cin / req1_cin, input, 1 bit: carry-in.
REQ-007 The block SHALL have ports req0_ready / req1_ready, output, 1 bit: the operation is accepted on an edge where valid and ready are both high.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit, and port rsp_ready, input, 1 bit: response handshake.
REQ-009 The block SHALL have port rsp_sum, output, W bits: the sum.
REQ-010 The block SHALL have port rsp_cout, output, 1 bit: the carry-out.
REQ-011 The block SHALL have port rsp_id, output, 1 bit: index of the requester served.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL instantiate exactly one 4-bit CLA (ports a, b, c0, s, c4) and time-share it; no other adder SHALL be used for the sum.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on accept.
- RUN->DONE after NIB RUN edges.
- DONE->IDLE on rsp_valid & rsp_ready.
REQ-015 reqN_ready SHALL be high only in IDLE, and only for the granted requester; it SHALL be combinational from state, both valids and the round-robin pointer.
REQ-016 Arbitration SHALL work as follows:
- if only one valid is high, that requester is granted;
- if both are high, the requester not served last is granted;
- the pointer updates only on accept.
REQ-017 On accept, the block SHALL:
- register a, b, cin and id;
- clear the nibble counter;
- take no further account of requester inputs until the next IDLE.
REQ-018 On RUN edge k (k = 0..NIB-1), the block SHALL:
- drive the CLA with operand nibble k and the carry register (cin for k = 0);
- write s into rsp_sum nibble k;
- load c4 into the carry register.
REQ-019 rsp_valid SHALL rise exactly NIB edges after the accepting edge; with NIB = 4, accept at edge E0 gives rsp_valid high after E4.
REQ-020 rsp_cout SHALL equal the carry register after the last nibble; {rsp_cout, rsp_sum} SHALL equal a + b + cin mod 2^(W+1).
REQ-021 In DONE, rsp_sum, rsp_cout and rsp_id SHALL hold stable while rsp_ready is low; there is no timeout.
REQ-022 After the response handshake the block SHALL spend at least one cycle in IDLE before the next accept (no same-edge bypass); minimum throughput is one operation per NIB+2 cycles.
REQ-023 rsp_sum SHALL be undefined to consumers outside DONE; rsp_valid SHALL be low outside DONE.
REQ-024 A valid deasserted before its accept SHALL cause no state change; the block SHALL impose no stability check on requesters.

Reset
REQ-025 On rst high, the block SHALL immediately, without waiting for a clock edge:
- enter IDLE;
- set rsp_valid, rsp_sum, rsp_cout, rsp_id, busy, the carry register and the counter to 0;
- set the round-robin pointer to 1, so requester 0 wins the first tie.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no response; the requester is not re-served unless it re-presents valid.
REQ-027 After rst deasserts, an accept SHALL be possible on the first rising edge.

Verification
REQ-028 req0: a=0x1234, b=0x4321, cin=0 -> rsp_sum=0x5555, rsp_cout=0, rsp_id=0; rsp_valid high exactly 4 edges after accept.
REQ-029 req1: a=0xFFFF, b=0x0001, cin=0 -> rsp_sum=0x0000, rsp_cout=1; a=0x7FFF, b=0x0000, cin=1 -> rsp_sum=0x8000, rsp_cout=0 (carry ripples across all nibbles).
REQ-030 Both valids held high from reset:
- served order is 0, 1, 0, 1;
- reqN_ready is never high for both requesters at once.
REQ-031 rsp_ready held low for 3 cycles in DONE:
- outputs remain stable;
- busy=1, both ready signals = 0;
- the accept occurs no earlier than 1 cycle after the handshake.
REQ-032 rst pulsed after the second RUN edge -> immediate IDLE, rsp_valid=0; a following request of 0xA5A5 + 0x5A5A, cin=1 -> rsp_sum=0x0000, rsp_cout=1.
REQ-033 Operands changed on the cycle after accept -> the result uses the originally accepted values.
